// File: rtl/seq_pkg.sv
// Shared types and default sizes for the Padovan stream checker.
package seq_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Self-synchronising checker for a Padovan stream v[n] = v[n-2] + v[n-3].
// Seeds from three samples, hunts for a run of matches, then flags mismatches.
module seq_checker
  import seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 2,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err,
  output logic             exp_valid,
  output logic [WIDTH-1:0] exp_data,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output state_t           state
);

  localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);

  // Handshake: in_valid qualifies in_data for one cycle; there is no ready,
  // every valid cycle is consumed. clr takes priority and drops the sample.

  // The oldest history entry only ever feeds the prediction, so it lives
  // folded into exp_data (= h2 + h1 after the shift) rather than its own register.
  logic [WIDTH-1:0]  h1, h0;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss;
  logic [1:0]        seed_cnt;

  logic              hit;
  logic [RUN_W-1:0]  run_inc;
  logic [MISS_W-1:0] miss_inc;
  logic              match_inc;
  logic              miss_evt;

  assign hit       = (in_data == exp_data);
  assign run_inc   = run + RUN_W'(1);
  assign miss_inc  = miss + MISS_W'(1);
  assign match_inc = !clr && in_valid && (state == LOCKED) && hit;
  assign miss_evt  = !clr && in_valid && (state == LOCKED) && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      h1        <= '0;
      h0        <= '0;
      run       <= '0;
      miss      <= '0;
      seed_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      exp_valid <= 1'b0;
      exp_data  <= '0;
    end else if (clr) begin
      state     <= SEED;
      h1        <= '0;
      h0        <= '0;
      run       <= '0;
      miss      <= '0;
      seed_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      exp_valid <= 1'b0;
      exp_data  <= '0;
    end else begin
      err <= 1'b0;
      if (in_valid) begin
        // Every accepted sample shifts in, matched or not.
        h1       <= h0;
        h0       <= in_data;
        exp_data <= h1 + h0;
        case (state)
          SEED: begin
            if (seed_cnt == 2'd2) begin
              state     <= HUNT;
              exp_valid <= 1'b1;
              seed_cnt  <= '0;
            end else begin
              seed_cnt <= seed_cnt + 2'd1;
            end
          end
          HUNT: begin
            if (!hit) begin
              run <= '0;
            end else if (run_inc == RUN_W'(LOCK_THRESH)) begin
              state  <= LOCKED;
              locked <= 1'b1;
              run    <= '0;
            end else begin
              run <= run_inc;
            end
          end
          LOCKED: begin
            if (hit) begin
              miss <= '0;
            end else begin
              err <= 1'b1;
              if (miss_inc == MISS_W'(LOSS_THRESH)) begin
                state  <= HUNT;
                locked <= 1'b0;
                miss   <= '0;
                run    <= '0;
              end else begin
                miss <= miss_inc;
              end
            end
          end
          default: state <= SEED;
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (match_inc),
    .cnt   (match_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (miss_evt),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: seeding, lock/loss, wrap, gaps, clr, async reset, saturation.
module tb_seq_checker;
  import seq_pkg::*;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          locked;
  logic          err;
  logic          exp_valid;
  logic [W-1:0]  exp_data;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] err_cnt;
  state_t        state;

  int errors = 0;
  int checks = 0;

  seq_checker #(
    .WIDTH       (W),
    .LOCK_THRESH (4),
    .LOSS_THRESH (2),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .locked    (locked),
    .err       (err),
    .exp_valid (exp_valid),
    .exp_data  (exp_data),
    .match_cnt (match_cnt),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled at that same point
  task automatic send(input logic v, input logic [W-1:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clr(input logic v, input logic [W-1:0] d);
    clr      = 1'b1;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, W'(locked), 0);
    chk({tag, "_err"}, W'(err), 0);
    chk({tag, "_exp_valid"}, W'(exp_valid), 0);
    chk({tag, "_exp_data"}, exp_data, 0);
    chk({tag, "_match_cnt"}, W'(match_cnt), 0);
    chk({tag, "_err_cnt"}, W'(err_cnt), 0);
    chk({tag, "_state"}, W'(state), W'(SEED));
  endtask

  logic [W-1:0] p2, p1, p0, nx;

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // seed 0,1,1 then hunt: first 2 mismatches (predicted 1), then 2,3,4,5 lock
    send(1, 0);
    send(1, 1);
    chk("seed2_exp_valid", W'(exp_valid), 0);
    send(1, 1);
    chk("seed3_exp_valid", W'(exp_valid), 1);
    chk("seed3_exp_data", exp_data, 1);
    chk("seed3_state", W'(state), W'(HUNT));
    send(1, 2);
    chk("hunt_miss_err", W'(err), 0);
    chk("hunt_miss_err_cnt", W'(err_cnt), 0);
    chk("hunt_miss_locked", W'(locked), 0);
    send(1, 2);
    send(1, 3);
    send(1, 4);
    chk("hunt3_locked", W'(locked), 0);
    send(1, 5);
    chk("lock_locked", W'(locked), 1);
    chk("lock_exp_data", exp_data, 7);
    chk("lock_match_cnt", W'(match_cnt), 0);

    // single miss: 8 instead of 7, then 9 = 4 + 5 matches
    send(1, 8);
    chk("miss1_err", W'(err), 1);
    chk("miss1_err_cnt", W'(err_cnt), 1);
    chk("miss1_locked", W'(locked), 1);
    chk("miss1_exp_data", exp_data, 9);
    send(1, 9);
    chk("recover_err", W'(err), 0);
    chk("recover_match_cnt", W'(match_cnt), 1);
    chk("recover_exp_data", exp_data, 13);

    // two consecutive misses drop lock; history (9,0,0) then 9,0,9,9 re-lock
    send(1, 0);
    chk("loss1_err", W'(err), 1);
    chk("loss1_err_cnt", W'(err_cnt), 2);
    chk("loss1_locked", W'(locked), 1);
    send(1, 0);
    chk("loss2_err", W'(err), 1);
    chk("loss2_err_cnt", W'(err_cnt), 3);
    chk("loss2_locked", W'(locked), 0);
    chk("loss2_exp_data", exp_data, 9);
    send(1, 9);
    send(1, 0);
    send(1, 9);
    chk("relock3_locked", W'(locked), 0);
    send(1, 9);
    chk("relock_locked", W'(locked), 1);
    chk("relock_match_cnt", W'(match_cnt), 1);
    send(1, 9);
    chk("relock_more_match_cnt", W'(match_cnt), 2);
    chk("relock_more_exp_data", exp_data, 18);

    // clr, then wrap-around seed
    do_clr(0, 0);
    chk_zero("clr_idle");
    send(1, 32'hFFFF_FFFF);
    send(1, 1);
    send(1, 1);
    chk("wrap_seed_exp_valid", W'(exp_valid), 1);
    chk("wrap_seed_exp_data", exp_data, 0);
    send(1, 0);
    chk("wrap_err", W'(err), 0);
    chk("wrap_err_cnt", W'(err_cnt), 0);
    chk("wrap_exp_data", exp_data, 2);

    // gapped stream: 2,1,2 completes the lock run, then 3 matches, 7 misses
    send(1, 2);
    send(0, 32'hDEAD_BEEF);
    chk("gap_hold_exp_data", exp_data, 1);
    send(1, 1);
    send(0, 0);
    send(1, 2);
    send(0, 0);
    chk("gap_locked", W'(locked), 1);
    chk("gap_exp_data", exp_data, 3);
    send(1, 3);
    send(0, 0);
    chk("gap_match_cnt", W'(match_cnt), 1);
    chk("gap_match_exp_data", exp_data, 3);
    send(1, 7);
    chk("gap_miss_err", W'(err), 1);
    chk("gap_miss_err_cnt", W'(err_cnt), 1);
    chk("gap_miss_exp_data", exp_data, 5);
    send(0, 5);
    chk("gap_err_pulse", W'(err), 0);
    chk("gap_err_cnt_hold", W'(err_cnt), 1);
    chk("gap_locked_hold", W'(locked), 1);
    do_clr(1, 5);
    chk_zero("clr_valid");

    // fresh seed after clr (dropped sample must not count), then saturation
    send(1, 0);
    send(1, 1);
    send(1, 1);
    chk("reseed_exp_data", exp_data, 1);
    send(1, 2);
    send(1, 2);
    send(1, 3);
    send(1, 4);
    send(1, 5);
    chk("reseed_locked", W'(locked), 1);
    p2 = 3;
    p1 = 4;
    p0 = 5;
    for (int i = 0; i < 17; i++) begin
      nx = p2 + p1;
      send(1, nx);
      p2 = p1;
      p1 = p0;
      p0 = nx;
    end
    chk("sat_match_cnt", W'(match_cnt), 15);
    chk("sat_err_cnt", W'(err_cnt), 0);
    chk("sat_locked", W'(locked), 1);

    // async reset pulse mid-cycle while locked
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    #2;
    rst_n = 1'b1;
    send(1, 0);
    send(1, 1);
    send(1, 1);
    chk("post_rst_exp_data", exp_data, 1);
    send(1, 2);
    send(1, 2);
    send(1, 3);
    send(1, 4);
    chk("post_rst_pre_lock", W'(locked), 0);
    send(1, 5);
    chk("post_rst_locked", W'(locked), 1);
    chk("post_rst_exp7", exp_data, 7);
    chk("post_rst_match_cnt", W'(match_cnt), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
